// File: rtl/pll_cfg_sequencer.sv
// Bus-master sequencer that reprograms the PLL register block (kp, ki, N, enable)
// from one valid/ready request, then waits for lock with a settle window and a timeout.
module pll_cfg_sequencer #(
  parameter int                 ADDR_W        = 32,
  parameter int                 DATA_W        = 32,
  parameter logic [ADDR_W-1:0]  BASE_ADDR     = 32'h8000_0000,
  parameter int                 SETTLE_CYCLES = 16,
  parameter int                 LOCK_TIMEOUT  = 4096
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [15:0]       req_kp,
  input  logic [15:0]       req_ki,
  input  logic [7:0]        req_n,
  output logic              bus_wen,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_request_stall,
  input  logic              pll_lock,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err_code,
  output logic [7:0]        active_n
);

  localparam int CNT_MAX = (SETTLE_CYCLES > LOCK_TIMEOUT) ? SETTLE_CYCLES : LOCK_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(LOCK_TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, DIS, WR_KP, WR_KI, WR_N, EN, SETTLE, WAIT_LOCK, ERR_DIS, FIN
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [15:0]      kp_q;
  logic [15:0]      ki_q;
  logic [7:0]       n_q;
  logic [CNT_W-1:0] cnt;
  logic             lock_meta;
  logic             lock_sync;
  logic [3:0]       reg_off;
  logic             accept;
  logic             wr_done;

  // req_ready is gated by reset so nothing is offered while the block is held
  assign req_ready = (state == IDLE) && HRESETn;
  assign accept    = req_valid && req_ready;
  assign wr_done   = bus_wen && !bus_request_stall;
  assign bus_addr  = BASE_ADDR + ADDR_W'(reg_off);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (accept) state_next = (req_n == 8'd0) ? FIN : DIS;
      DIS:       if (wr_done) state_next = WR_KP;
      WR_KP:     if (wr_done) state_next = WR_KI;
      WR_KI:     if (wr_done) state_next = WR_N;
      WR_N:      if (wr_done) state_next = EN;
      EN:        if (wr_done) state_next = SETTLE;
      SETTLE:    if (cnt == '0) state_next = WAIT_LOCK;
      // lock takes priority over a simultaneous timeout expiry
      WAIT_LOCK: begin
        if (lock_sync)        state_next = FIN;
        else if (cnt == '0)   state_next = ERR_DIS;
      end
      ERR_DIS:   if (wr_done) state_next = FIN;
      FIN:       state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    bus_wen   = 1'b0;
    reg_off   = 4'h0;
    bus_wdata = '0;
    busy      = (state != IDLE);
    done      = (state == FIN);
    case (state)
      DIS:     begin bus_wen = 1'b1; reg_off = 4'hC; end
      WR_KP:   begin bus_wen = 1'b1; reg_off = 4'h0; bus_wdata = DATA_W'(kp_q); end
      WR_KI:   begin bus_wen = 1'b1; reg_off = 4'h4; bus_wdata = DATA_W'(ki_q); end
      WR_N:    begin bus_wen = 1'b1; reg_off = 4'h8; bus_wdata = DATA_W'(n_q); end
      EN:      begin bus_wen = 1'b1; reg_off = 4'hC; bus_wdata = DATA_W'(1); end
      ERR_DIS: begin bus_wen = 1'b1; reg_off = 4'hC; end
      default: ;
    endcase
  end

  // Request capture, lock synchronizer, settle/timeout counter and status
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      kp_q      <= '0;
      ki_q      <= '0;
      n_q       <= '0;
      cnt       <= '0;
      lock_meta <= 1'b0;
      lock_sync <= 1'b0;
      err_code  <= 2'd0;
      active_n  <= 8'd0;
    end else begin
      lock_meta <= pll_lock;
      lock_sync <= lock_meta;
      if (accept) begin
        kp_q     <= req_kp;
        ki_q     <= req_ki;
        n_q      <= req_n;
        err_code <= (req_n == 8'd0) ? 2'd2 : 2'd0;
      end
      case (state)
        EN:     if (wr_done) cnt <= SETTLE_LOAD;
        SETTLE: begin
          if (cnt == '0) cnt <= TIMEOUT_LOAD;
          else           cnt <= cnt - CNT_W'(1);
        end
        WAIT_LOCK: begin
          if (lock_sync) begin
            active_n <= n_q;
          end else if (cnt == '0) begin
            active_n <= 8'd0;
            err_code <= 2'd1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pll_cfg_sequencer.sv
// Randomized self-checking bench for pll_cfg_sequencer; expected bus traffic and
// done timing come from a cycle schedule computed from the sequencing rules.
module tb_pll_cfg_sequencer;

  localparam int          SETTLE  = 16;
  localparam int          TIMEOUT = 8;
  localparam logic [31:0] BASE    = 32'h8000_0000;
  localparam int          MAXC    = 256;

  logic        tb_clk_out = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_kp;
  logic [15:0] req_ki;
  logic [7:0]  req_n;
  logic        bus_wen;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_request_stall;
  logic        pll_lock;
  logic        busy;
  logic        done;
  logic [1:0]  err_code;
  logic [7:0]  active_n;

  int          n_compared   = 0;
  int          n_mismatched = 0;
  logic [7:0]  model_active_n;
  bit          stall_w[MAXC];
  bit          lock_w[MAXC];

  pll_cfg_sequencer #(
    .ADDR_W(32), .DATA_W(32), .BASE_ADDR(BASE),
    .SETTLE_CYCLES(SETTLE), .LOCK_TIMEOUT(TIMEOUT)
  ) dut (
    .HCLK(tb_clk_out), .HRESETn(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_kp(req_kp), .req_ki(req_ki), .req_n(req_n),
    .bus_wen(bus_wen), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_request_stall(bus_request_stall), .pll_lock(pll_lock),
    .busy(busy), .done(done), .err_code(err_code), .active_n(active_n)
  );

  always #5 tb_clk_out = ~tb_clk_out;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_wen"},   64'(bus_wen),   64'(0));
    checkOutput({tag, "_addr"},  64'(bus_addr),  64'(BASE));
    checkOutput({tag, "_wdata"}, 64'(bus_wdata), 64'(0));
    checkOutput({tag, "_ready"}, 64'(req_ready), 64'(0));
    checkOutput({tag, "_busy"},  64'(busy),      64'(0));
    checkOutput({tag, "_done"},  64'(done),      64'(0));
    checkOutput({tag, "_err"},   64'(err_code),  64'(0));
    checkOutput({tag, "_act"},   64'(active_n),  64'(0));
  endtask

  // stall_mode: 0 none, 1 random, 2 three cycles during WR_KI
  // lock_mode: 0 high, 1 low, 2 late rise, 3 drop at EN for 5 cycles, 4 noisy
  task automatic applyStimulus(input logic [15:0] kp, input logic [15:0] ki, input logic [7:0] n,
                               input int stall_mode, input int lock_mode);
    logic [31:0] w_addr[6];
    logic [31:0] w_data[6];
    bit          exp_wen[MAXC];
    logic [31:0] exp_addr[MAXC];
    logic [31:0] exp_data[MAXC];
    int          c, d, w_entry, en_cycle, exp_err, k;
    bit          locked;
    logic [7:0]  exp_act;

    w_addr = '{BASE + 32'hC, BASE, BASE + 32'h4, BASE + 32'h8, BASE + 32'hC, BASE + 32'hC};
    w_data = '{32'd0, 32'(kp), 32'(ki), 32'(n), 32'd1, 32'd0};
    for (int i = 0; i < MAXC; i++) begin
      exp_wen[i]  = 1'b0;
      exp_addr[i] = '0;
      exp_data[i] = '0;
      stall_w[i]  = (stall_mode == 1) ? ((i < 100) && ($urandom_range(0, 3) == 0))
                  : (stall_mode == 2) ? (i >= 3 && i <= 5) : 1'b0;
    end

    // Write schedule: each write occupies cycles until one without stall
    c = 1;
    for (int i = 0; i < 5; i++) begin
      do begin
        exp_wen[c] = 1'b1; exp_addr[c] = w_addr[i]; exp_data[c] = w_data[i]; c++;
      end while (stall_w[c-1]);
    end
    en_cycle = c - 1;
    w_entry  = c + SETTLE;

    k = $urandom_range(0, 50);
    for (int i = 0; i < MAXC; i++) begin
      case (lock_mode)
        0:       lock_w[i] = 1'b1;
        1:       lock_w[i] = 1'b0;
        2:       lock_w[i] = (i >= k);
        3:       lock_w[i] = (i < en_cycle) || (i >= en_cycle + 5);
        default: lock_w[i] = ($urandom_range(0, 5) == 0);
      endcase
    end

    if (n == 8'd0) begin
      for (int i = 0; i < MAXC; i++) exp_wen[i] = 1'b0;
      d = 1; exp_err = 2; exp_act = model_active_n;
    end else begin
      locked = 1'b0;
      d = 0;
      for (int cc = w_entry; cc < w_entry + TIMEOUT && !locked; cc++)
        if (lock_w[cc-2]) begin locked = 1'b1; d = cc + 1; end
      if (locked) begin
        exp_err = 0; exp_act = n;
      end else begin
        c = w_entry + TIMEOUT;
        do begin
          exp_wen[c] = 1'b1; exp_addr[c] = w_addr[5]; exp_data[c] = w_data[5]; c++;
        end while (stall_w[c-1]);
        d = c; exp_err = 1; exp_act = 8'd0;
      end
    end

    bus_request_stall = 1'b0;
    req_valid         = 1'b0;
    pll_lock          = lock_w[0];
    repeat (3) @(posedge tb_clk_out);

    for (int cy = 0; cy <= d + 1; cy++) begin
      @(posedge tb_clk_out);
      #1;
      bus_request_stall = stall_w[cy];
      pll_lock          = lock_w[cy];
      if (cy == 0) begin
        req_valid = 1'b1; req_kp = kp; req_ki = ki; req_n = n;
      end else if (cy <= d) begin
        req_valid = 1'($urandom_range(0, 1));
        req_kp = 16'($urandom); req_ki = 16'($urandom); req_n = 8'($urandom);
      end else begin
        req_valid = 1'b0;
      end
      @(negedge tb_clk_out);
      checkOutput($sformatf("wen@%0d", cy), 64'(bus_wen), 64'(exp_wen[cy]));
      if (exp_wen[cy]) begin
        checkOutput($sformatf("addr@%0d", cy),  64'(bus_addr),  64'(exp_addr[cy]));
        checkOutput($sformatf("wdata@%0d", cy), 64'(bus_wdata), 64'(exp_data[cy]));
      end
      checkOutput($sformatf("done@%0d", cy),  64'(done),      64'(cy == d));
      checkOutput($sformatf("busy@%0d", cy),  64'(busy),      64'(cy >= 1 && cy <= d));
      checkOutput($sformatf("ready@%0d", cy), 64'(req_ready), 64'(cy == 0 || cy == d + 1));
      if (cy == d) begin
        checkOutput("err_code", 64'(err_code), 64'(exp_err));
        checkOutput("active_n", 64'(active_n), 64'(exp_act));
      end
    end
    req_valid         = 1'b0;
    bus_request_stall = 1'b0;
    model_active_n    = exp_act;
  endtask

  // Start a normal request, then pull reset asynchronously while WR_N is on the bus
  task automatic applyMidReset();
    bus_request_stall = 1'b0;
    pll_lock          = 1'b1;
    @(posedge tb_clk_out);
    #1;
    req_valid = 1'b1; req_kp = 16'h1234; req_ki = 16'h0042; req_n = 8'd50;
    @(posedge tb_clk_out);
    #1;
    req_valid = 1'b0;
    repeat (3) @(posedge tb_clk_out);
    @(negedge tb_clk_out);
    checkOutput("midrst_wr_n_addr", 64'(bus_addr), 64'(BASE + 32'h8));
    checkOutput("midrst_wr_n_wen",  64'(bus_wen),  64'(1));
    #2 rst_n = 1'b0;
    #1 checkResetState("midrst");
    repeat (2) @(negedge tb_clk_out);
    rst_n = 1'b1;
    model_active_n = 8'd0;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_kp = '0; req_ki = '0; req_n = '0;
    bus_request_stall = 1'b0; pll_lock = 1'b0;
    model_active_n = 8'd0;
    #1 checkResetState("por");
    repeat (2) @(negedge tb_clk_out);
    rst_n = 1'b1;
    @(negedge tb_clk_out);
    checkOutput("ready_after_reset", 64'(req_ready), 64'(1));

    applyStimulus(16'h0100, 16'h0008, 8'd72, 0, 0);
    applyStimulus(16'h0100, 16'h0008, 8'd72, 2, 0);
    applyStimulus(16'h0BAD, 16'h0F00, 8'd0,  0, 0);
    applyStimulus(16'h0100, 16'h0008, 8'd72, 0, 1);
    applyStimulus(16'h0200, 16'h0010, 8'd40, 0, 3);
    applyStimulus(16'h0300, 16'h0020, 8'd99, 1, 2);
    applyMidReset();
    applyStimulus(16'h0100, 16'h0008, 8'd72, 0, 0);

    for (int t = 0; t < 30; t++) begin
      logic [7:0] rn;
      rn = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      applyStimulus(16'($urandom), 16'($urandom), rn,
                    int'($urandom_range(0, 1)), int'($urandom_range(0, 4)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/pll_cfg_sequencer.md
# pll_cfg_sequencer

Bus-master sequencer that reprograms the AHB-attached PLL register block (kp at byte offset 0x0, ki at 0x4, feedback divider N at 0x8, enable at 0xC) from a single valid/ready request. It disables the PLL, loads the gains and divider, re-enables it, waits out a settle window, then waits for lock with a timeout. Status outputs report completion and errors. It sits between the clock-management software or FSM and the PLL's bus_protocol register port, replacing manual four-write programming sequences.

## Interface
- ADDR_W, 32, bus address width
- DATA_W, 32, bus data width
- BASE_ADDR, 32'h8000_0000, PLL register base address
- SETTLE_CYCLES, 16, HCLK cycles after enable during which lock is ignored (≥1)
- LOCK_TIMEOUT, 4096, max HCLK cycles spent in WAIT_LOCK (≥1)

Ports:
- HCLK  in  1  sole clock
- HRESETn  in  1  asynchronous, active-low reset
- req_valid  in  1  new configuration request
- req_ready  out  1  high only in IDLE
- req_kp  in  16  proportional gain
- req_ki  in  16  integral gain
- req_n  in  8  feedback divider (0 illegal)
- bus_wen  out  1  register write strobe
- bus_addr  out  ADDR_W  BASE_ADDR + byte offset
- bus_wdata  out  DATA_W  zero-extended write data
- bus_request_stall  in  1  slave stall; write holds while high
- pll_lock  in  1  PLL lock, asynchronous to HCLK
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at end of every accepted request
- err_code  out  2  0 ok, 1 lock timeout, 2 bad param; valid from done until next acceptance
- active_n  out  8  last N that achieved lock; 0 = unknown

## Operation
- States: IDLE, DIS, WR_KP, WR_KI, WR_N, EN, SETTLE, WAIT_LOCK, ERR_DIS, FIN.
- IDLE: req_ready=1. Acceptance occurs when req_valid&&req_ready. Request fields are captured into internal registers at acceptance. req_n==0 → FIN with err_code=2 and no bus writes. Otherwise → DIS.
- Write states drive bus_wen=1, with bus_addr/bus_wdata as follows: DIS 0xC/0, WR_KP 0x0/kp, WR_KI 0x4/ki, WR_N 0x8/n, EN 0xC/1, ERR_DIS 0xC/0.
- A write completes in a cycle where bus_wen=1 and bus_request_stall=0. The state advances on completion. While stalled, address and data stay stable.
- SETTLE: down-counter loaded with SETTLE_CYCLES-1. Lock is ignored. → WAIT_LOCK when the count reaches 0.
- WAIT_LOCK: counter loaded with LOCK_TIMEOUT-1.
  - lock_sync=1 → FIN with err_code=0, and active_n ← captured n.
  - Counter at 0 with lock_sync=0 → ERR_DIS, then FIN with err_code=1. active_n ← 0.
  - Lock wins if it is seen on the same cycle the counter expires.
- FIN: done=1 for one cycle → IDLE.
- pll_lock passes through a 2-flop synchronizer (lock_sync), with reset value 0.
- Counters are wide enough for their parameters; they do not wrap.

## Timing
- Reset values: req_ready=0 during reset and 1 after it. bus_wen=0, bus_addr=BASE_ADDR, bus_wdata=0, busy=0, done=0, err_code=0, active_n=0, state=IDLE. The synchronizer is cleared.
- Assertion of HRESETn mid-sequence drops bus_wen immediately (asynchronous). An in-flight write is abandoned, and PLL register contents are undefined.
- No-stall latency, with acceptance at cycle 0:
  - Writes occupy cycles 1-5.
  - SETTLE occupies cycles 6 … 5+SETTLE_CYCLES.
  - WAIT_LOCK starts at 6+SETTLE_CYCLES.
  - done is asserted the cycle after lock_sync is first seen high in WAIT_LOCK.
- Each stall cycle adds exactly one cycle. Stalls never affect the SETTLE or timeout counters.
- Bad-param request: done at cycle 1.
- Timeout: ERR_DIS is entered LOCK_TIMEOUT cycles after WAIT_LOCK entry. done follows ERR_DIS completion by one cycle.
- req_valid in non-IDLE states is ignored, and no request is queued.
- busy falls in the same cycle the state returns to IDLE, which is the cycle after done.

## Test plan
- Reset, then request kp=0x0100, ki=0x0008, n=72, with pll_lock tied high → writes (0xC,0),(0x0,0x100),(0x4,8),(0x8,72),(0xC,1) on cycles 1-5. done at 7+SETTLE_CYCLES, err_code=0, active_n=72.
- Same request with bus_request_stall high for 3 cycles during WR_KI → bus_addr/bus_wdata stay at 0x4/8 while stalled, and done is delayed by exactly 3 cycles.
- pll_lock held low, LOCK_TIMEOUT=8 → ERR_DIS write (0xC,0), then done with err_code=1, active_n=0.
- req_n=0 → no bus_wen, done at cycle 1, err_code=2, active_n unchanged.
- pll_lock high from before the request, then dropped at EN and reasserted 5 cycles later → lock is ignored during SETTLE, and done occurs only after the resynchronized lock is seen in WAIT_LOCK.
- HRESETn asserted during WR_N → bus_wen=0 immediately, all outputs at reset values, and a new request after reset completes normally.
